dbscan_density_accumulator: RTL

//  Downstream consumer of the sorting-chain control. Over each N-cycle DBSCAN window it

---
 rtl/dbscan_density_accumulator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dbscan_density_accumulator.sv
// Per-window neighbour counter and minimum-distance tracker for DBSCAN.
// On each end-of-window pulse it latches a core/noise result, offered to the output routine with valid/ready.
module dbscan_density_accumulator #(
   parameter int W = 16,
   parameter int C = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         final_in,
   input  logic         sample_valid,
   input  logic [W-1:0] sample_dist,
   input  logic [W-1:0] eps,
   input  logic [C-1:0] min_pts,
   output logic         result_valid,
   input  logic         result_ready,
   output logic [C-1:0] neighbour_cnt,
   output logic [W-1:0] min_dist,
   output logic         is_core,
   output logic         sat,
   output logic         overrun
);

   // Handshake: a result transfers on a clock edge where result_valid and result_ready
   // are both high. While result_valid is high the result fields do not change,
   // except when a new window report overwrites them (flagged by overrun).

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [C-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] MIN_INIT = '1;

   state_t       state_q, state_d;
   logic [C-1:0] acc_cnt_q, acc_cnt_d;
   logic [W-1:0] acc_min_q, acc_min_d;
   logic         acc_sat_q, acc_sat_d;
   logic         result_valid_q, result_valid_d;
   logic [C-1:0] neighbour_cnt_q, neighbour_cnt_d;
   logic [W-1:0] min_dist_q, min_dist_d;
   logic         is_core_q, is_core_d;
   logic         sat_q, sat_d;
   logic         overrun_q, overrun_d;

   logic         hit;
   logic [C-1:0] cnt_next;
   logic [W-1:0] min_next;
   logic         sat_next;
   logic         accept;

   always_comb begin
      hit      = sample_valid && (sample_dist <= eps);
      cnt_next = acc_cnt_q;
      sat_next = acc_sat_q;
      if (hit) begin
         if (acc_cnt_q == CNT_MAX) begin
            sat_next = 1'b1;
         end else begin
            cnt_next = acc_cnt_q + C'(1);
         end
      end
      min_next = (sample_valid && (sample_dist < acc_min_q)) ? sample_dist : acc_min_q;
      accept   = result_valid_q && result_ready;
   end

   always_comb begin
      state_d         = state_q;
      acc_cnt_d       = acc_cnt_q;
      acc_min_d       = acc_min_q;
      acc_sat_d       = acc_sat_q;
      result_valid_d  = result_valid_q;
      neighbour_cnt_d = neighbour_cnt_q;
      min_dist_d      = min_dist_q;
      is_core_d       = is_core_q;
      sat_d           = sat_q;
      overrun_d       = overrun_q;

      if (accept) begin
         result_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (final_in) begin
               // The report includes this cycle's sample; the next window starts clean.
               neighbour_cnt_d = cnt_next;
               min_dist_d      = min_next;
               is_core_d       = (cnt_next >= min_pts);
               sat_d           = sat_next;
               result_valid_d  = 1'b1;
               if (result_valid_q && !result_ready) begin
                  overrun_d = 1'b1;
               end
               acc_cnt_d = '0;
               acc_min_d = MIN_INIT;
               acc_sat_d = 1'b0;
            end else begin
               acc_cnt_d = cnt_next;
               acc_min_d = min_next;
               acc_sat_d = sat_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         acc_cnt_q       <= '0;
         acc_min_q       <= MIN_INIT;
         acc_sat_q       <= 1'b0;
         result_valid_q  <= 1'b0;
         neighbour_cnt_q <= '0;
         min_dist_q      <= MIN_INIT;
         is_core_q       <= 1'b0;
         sat_q           <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         acc_cnt_q       <= acc_cnt_d;
         acc_min_q       <= acc_min_d;
         acc_sat_q       <= acc_sat_d;
         result_valid_q  <= result_valid_d;
         neighbour_cnt_q <= neighbour_cnt_d;
         min_dist_q      <= min_dist_d;
         is_core_q       <= is_core_d;
         sat_q           <= sat_d;
         overrun_q       <= overrun_d;
      end
   end

   assign result_valid  = result_valid_q;
   assign neighbour_cnt = neighbour_cnt_q;
   assign min_dist      = min_dist_q;
   assign is_core       = is_core_q;
   assign sat           = sat_q;
   assign overrun       = overrun_q;

endmodule
